// File: rtl/btn_pkg.sv
// Shared types, width helper and 100 MHz timing defaults for the button conditioner.
// The optional auto-repeat feature is enabled with the BTN_AUTOREPEAT_EN macro.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        LONG_HELD
    } btn_state_e;

    // Defaults for a 100 MHz clock: 1 ms qualify, 0.5 s long press, 100 ms repeat.
    localparam int unsigned DEF_STABLE_CNT = 100_000;
    localparam int unsigned DEF_LONG_CNT   = 50_000_000;
    localparam int unsigned DEF_REPEAT_CNT = 10_000_000;

    // Counter width able to hold values up to max_count-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count <= 1) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, exact stable-count debounce, press/release/long
// pulses and the hold FSM. Auto-repeat pulses exist only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
    parameter int unsigned LONG_CNT   = DEF_LONG_CNT,
    parameter int unsigned REPEAT_CNT = DEF_REPEAT_CNT,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_pin,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long,
    output logic btn_repeat
);

    localparam int unsigned DB_W   = cnt_width(STABLE_CNT);
    localparam int unsigned HOLD_W = cnt_width(LONG_CNT + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(STABLE_CNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CNT - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    btn_state_e        state_q, state_d;
    logic              differs, accept;

    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        sync1_d   = (ACTIVE_LOW != 0) ? ~btn_pin : btn_pin;
        sync2_d   = sync1_q;

        differs   = (sync2_q != level_q);
        accept    = differs && (db_cnt_q == DB_LAST);
        db_cnt_d  = '0;
        if (differs && !accept) db_cnt_d = db_cnt_q + 1'b1;

        level_d   = accept ? sync2_q : level_q;
        press_d   = accept & sync2_q;
        release_d = accept & ~sync2_q;

        hold_d = '0;
        if (level_q) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;

        // A release accepted on the same edge wins over a long press reaching its count.
        long_d = (state_q == PRESSED) && level_q && (hold_q == HOLD_PRE) && !release_d;

        state_d = state_q;
        unique case (state_q)
            RELEASED:  if (press_d) state_d = PRESSED;
            PRESSED: begin
                if (release_d)   state_d = RELEASED;
                else if (long_d) state_d = LONG_HELD;
            end
            LONG_HELD: if (release_d) state_d = RELEASED;
            default:   state_d = RELEASED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            hold_q    <= '0;
            state_q   <= RELEASED;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            hold_q    <= hold_d;
            state_q   <= state_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_W = cnt_width(REPEAT_CNT);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CNT - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             repeat_q, repeat_d;

    // Counter starts at 0 on the btn_long edge, so the first pulse lands REPEAT_CNT cycles later.
    always_comb begin
        rpt_cnt_d = '0;
        repeat_d  = 1'b0;
        if ((state_q == LONG_HELD) && !release_d) begin
            if (rpt_cnt_q == RPT_LAST) repeat_d  = 1'b1;
            else                       rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign btn_repeat = repeat_q;
`else
    assign btn_repeat = 1'b0;
`endif

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel button conditioner: one independent btn_debounce_ch per input pin.
// Define BTN_AUTOREPEAT_EN to enable auto-repeat pulses on btn_repeat.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
    parameter int unsigned LONG_CNT   = DEF_LONG_CNT,
    parameter int unsigned REPEAT_CNT = DEF_REPEAT_CNT,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_repeat
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CNT (STABLE_CNT),
            .LONG_CNT   (LONG_CNT),
            .REPEAT_CNT (REPEAT_CNT),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_pin     (btn_in[g]),
            .btn_level   (btn_level[g]),
            .btn_press   (btn_press[g]),
            .btn_release (btn_release[g]),
            .btn_long    (btn_long[g]),
            .btn_repeat  (btn_repeat[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi: directed scenarios plus random bouncing
// stimulus, compared every cycle against a pin-history reference model.
module tb_btn_debounce_multi;

    localparam int N_CH       = 2;
    localparam int STABLE_CNT = 4;
    localparam int LONG_CNT   = 20;
    localparam int REPEAT_CNT = 5;
    localparam int ACTIVE_LOW = 0;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

    always #5 clk = ~clk;

    btn_debounce_multi #(
        .N_CH       (N_CH),
        .STABLE_CNT (STABLE_CNT),
        .LONG_CNT   (LONG_CNT),
        .REPEAT_CNT (REPEAT_CNT),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .btn_repeat  (btn_repeat)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle time %0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pin history per channel; hist[ch][j] is the pin seen j edges ago.
    logic            hist [N_CH][STABLE_CNT+2];
    logic [N_CH-1:0] m_level, e_press, e_release, e_long, e_repeat;
    int              press_cyc [N_CH];
    int              long_cyc  [N_CH];
    int              cyc = 0;

    // Observations on channel 0 for the directed scenarios.
    int n_press0 = 0, n_rel0 = 0, n_long0 = 0, n_rep0 = 0;
    int press_at0 = -1, long_at0 = -1;
    int rep_at0 [3];

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int j = 0; j < STABLE_CNT + 2; j++) hist[ch][j] = 1'b0;
            press_cyc[ch] = -1;
            long_cyc[ch]  = -1;
        end
        m_level = '0; e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
    endtask

    // The level flips once the synchronised pin (2 edges late) has differed from it
    // on each of the last STABLE_CNT edges; long/repeat are timed from the press cycle.
    task automatic model_edge();
        logic all_diff;
        e_press = '0; e_release = '0; e_long = '0; e_repeat = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int j = STABLE_CNT + 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
            hist[ch][0] = (ACTIVE_LOW != 0) ? ~btn_in[ch] : btn_in[ch];
            all_diff = 1'b1;
            for (int j = 2; j <= STABLE_CNT + 1; j++)
                if (hist[ch][j] == m_level[ch]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[ch] = ~m_level[ch];
                if (m_level[ch]) begin
                    e_press[ch]   = 1'b1;
                    press_cyc[ch] = cyc;
                end else begin
                    e_release[ch] = 1'b1;
                    press_cyc[ch] = -1;
                end
                long_cyc[ch] = -1;
            end else if (m_level[ch]) begin
                if (press_cyc[ch] >= 0 && cyc - press_cyc[ch] == LONG_CNT) begin
                    e_long[ch]   = 1'b1;
                    long_cyc[ch] = cyc;
                end
`ifdef BTN_AUTOREPEAT_EN
                if (long_cyc[ch] >= 0 && cyc > long_cyc[ch] &&
                    (cyc - long_cyc[ch]) % REPEAT_CNT == 0)
                    e_repeat[ch] = 1'b1;
`endif
            end
        end
    endtask

    // One clock: model updates at the rising edge, DUT compared on the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else       model_edge();
        @(negedge clk);
        check("level",   32'(btn_level),   32'(m_level));
        check("press",   32'(btn_press),   32'(e_press));
        check("release", 32'(btn_release), 32'(e_release));
        check("long",    32'(btn_long),    32'(e_long));
        check("repeat",  32'(btn_repeat),  32'(e_repeat));
        if (btn_press[0])   begin n_press0++; press_at0 = cyc; end
        if (btn_long[0])    begin n_long0++;  long_at0  = cyc; end
        if (btn_release[0]) n_rel0++;
        if (btn_repeat[0]) begin
            if (n_rep0 < 3) rep_at0[n_rep0] = cyc;
            n_rep0++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset_check(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check({tag, "_level"},   32'(btn_level),   32'd0);
        check({tag, "_press"},   32'(btn_press),   32'd0);
        check({tag, "_release"}, 32'(btn_release), 32'd0);
        check({tag, "_long"},    32'(btn_long),    32'd0);
    endtask

    int c0, p0, l0, r0;
    int remain [N_CH];

    initial begin
        reset  = 1'b1;
        btn_in = '0;
        model_reset();
        steps(3);
        check("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_long, btn_repeat}), 32'd0);
        reset = 1'b0;
        steps(3);

        // Clean press on ch0: accepted on the 6th edge after the pin changes.
        c0 = cyc; p0 = n_press0;
        btn_in = 2'b01;
        steps(5);
        check("clean_pre_level", 32'(btn_level[0]), 32'd0);
        step();
        check("clean_level", 32'(btn_level[0]), 32'd1);
        check("clean_press_cycle", 32'(press_at0), 32'(c0 + 6));
        check("clean_ch1_quiet", 32'(btn_level[1]), 32'd0);
        steps(4);
        btn_in = 2'b00;
        steps(12);

        // Bounce 1,0,1,0 then steady 1: exactly one press, 6 edges after the settle.
        p0 = n_press0;
        btn_in[0] = 1'b1; step();
        btn_in[0] = 1'b0; step();
        btn_in[0] = 1'b1; step();
        btn_in[0] = 1'b0; step();
        c0 = cyc;
        btn_in[0] = 1'b1;
        steps(5);
        check("bounce_no_press", 32'(n_press0 - p0), 32'd0);
        step();
        check("bounce_press_once", 32'(n_press0 - p0), 32'd1);
        check("bounce_press_cycle", 32'(press_at0), 32'(c0 + 6));
        steps(4);
        btn_in[0] = 1'b0;
        steps(12);

        // Long press: btn_long once, 20 cycles after btn_press; release still pulses.
        l0 = n_long0; r0 = n_rel0;
        btn_in[0] = 1'b1;
        steps(6 + 30);
        check("long_once", 32'(n_long0 - l0), 32'd1);
        check("long_delay", 32'(long_at0 - press_at0), 32'(LONG_CNT));
        btn_in[0] = 1'b0;
        steps(12);
        check("long_release", 32'(n_rel0 - r0), 32'd1);
        check("long_no_second", 32'(n_long0 - l0), 32'd1);

        // Short press: press and release pulse, no long.
        l0 = n_long0; r0 = n_rel0; p0 = n_press0;
        btn_in[0] = 1'b1;
        steps(6 + 10);
        btn_in[0] = 1'b0;
        steps(12);
        check("short_press", 32'(n_press0 - p0), 32'd1);
        check("short_release", 32'(n_rel0 - r0), 32'd1);
        check("short_no_long", 32'(n_long0 - l0), 32'd0);

        // Auto-repeat timing after the long pulse (or silence when the feature is off).
        n_rep0 = 0;
        btn_in[0] = 1'b1;
        steps(6 + 40);
`ifdef BTN_AUTOREPEAT_EN
        check("repeat_1", 32'(rep_at0[0] - long_at0), 32'(REPEAT_CNT));
        check("repeat_2", 32'(rep_at0[1] - long_at0), 32'(2 * REPEAT_CNT));
        check("repeat_3", 32'(rep_at0[2] - long_at0), 32'(3 * REPEAT_CNT));
`else
        check("repeat_off", 32'(n_rep0), 32'd0);
`endif

        // Reset while ch0 is in LONG_HELD, button still held: fresh press after reset.
        async_reset_check("rst_long");
        steps(2);
        reset = 1'b0;
        c0 = cyc; p0 = n_press0;
        steps(6);
        check("rst_repress_once", 32'(n_press0 - p0), 32'd1);
        check("rst_repress_cycle", 32'(press_at0), 32'(c0 + 6));
        btn_in = '0;
        steps(12);

        // Random bouncing and holds on both channels, one asynchronous reset midway.
        for (int ch = 0; ch < N_CH; ch++) remain[ch] = 0;
        for (int t = 0; t < 2500; t++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (remain[ch] == 0) begin
                    int r;
                    btn_in[ch] = 1'($urandom_range(0, 1));
                    r = int'($urandom_range(0, 9));
                    if (r < 5)      remain[ch] = int'($urandom_range(1, 3));
                    else if (r < 9) remain[ch] = int'($urandom_range(4, 15));
                    else            remain[ch] = int'($urandom_range(20, 45));
                end
                remain[ch]--;
            end
            if (t == 1200) async_reset_check("rst_rand");
            if (t == 1203) reset = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
